// File: rtl/aib_axi_traffic_gen.sv
// rtl/aib_axi_traffic_gen.sv - AXI4 write/read-back traffic generator for AIB die-to-die bring-up
// Purpose: each burst writes an INCR pattern, waits for B, reads the burst back and compares.
//          pass/err_cnt report the outcome of the whole test.
// Ports:
//   clk_wr, rst_wr_n                          clock, async active-low reset
//   start, base_addr, burst_len, num_bursts,  test launch pulse and configuration,
//   seed                                      latched on start while idle
//   busy, done, pass, err_cnt                 test status
//   m_axi_aw*/w*/b*/ar*/r*                    AXI4 master port (single ID, one transaction in flight)
module aib_axi_traffic_gen #(
    parameter int ADDRWIDTH = 32,
    parameter int IDWIDTH   = 4,
    parameter int TXN_ID    = 0,
    parameter int DATAWIDTH = 128
) (
    input  logic                   clk_wr,
    input  logic                   rst_wr_n,
    input  logic                   start,
    input  logic [ADDRWIDTH-1:0]   base_addr,
    input  logic [7:0]             burst_len,
    input  logic [15:0]            num_bursts,
    input  logic [31:0]            seed,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [15:0]            err_cnt,
    output logic [IDWIDTH-1:0]     m_axi_awid,
    output logic [ADDRWIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]             m_axi_awlen,
    output logic [2:0]             m_axi_awsize,
    output logic [1:0]             m_axi_awburst,
    output logic                   m_axi_awvalid,
    input  logic                   m_axi_awready,
    output logic [IDWIDTH-1:0]     m_axi_wid,
    output logic [DATAWIDTH-1:0]   m_axi_wdata,
    output logic [DATAWIDTH/8-1:0] m_axi_wstrb,
    output logic                   m_axi_wlast,
    output logic                   m_axi_wvalid,
    input  logic                   m_axi_wready,
    input  logic [IDWIDTH-1:0]     m_axi_bid,
    input  logic [1:0]             m_axi_bresp,
    input  logic                   m_axi_bvalid,
    output logic                   m_axi_bready,
    output logic [IDWIDTH-1:0]     m_axi_arid,
    output logic [ADDRWIDTH-1:0]   m_axi_araddr,
    output logic [7:0]             m_axi_arlen,
    output logic [2:0]             m_axi_arsize,
    output logic [1:0]             m_axi_arburst,
    output logic                   m_axi_arvalid,
    input  logic                   m_axi_arready,
    input  logic [IDWIDTH-1:0]     m_axi_rid,
    input  logic [DATAWIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]             m_axi_rresp,
    input  logic                   m_axi_rlast,
    input  logic                   m_axi_rvalid,
    output logic                   m_axi_rready
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AW   = 3'd1;
    localparam logic [2:0] S_W    = 3'd2;
    localparam logic [2:0] S_B    = 3'd3;
    localparam logic [2:0] S_AR   = 3'd4;
    localparam logic [2:0] S_R    = 3'd5;
    localparam logic [2:0] S_FIN  = 3'd6;

    localparam logic [IDWIDTH-1:0] ID = IDWIDTH'(TXN_ID);

    logic [2:0]           state;
    logic [7:0]           cfg_len;
    logic [31:0]          cfg_seed;
    logic [ADDRWIDTH-1:0] cur_addr;
    logic [15:0]          bursts_left;
    logic [7:0]           beat_cnt;
    logic [31:0]          burst_k;
    logic                 pass_q;

    logic                 start_ok;
    logic                 last_beat;
    logic [31:0]          beat_pat;
    logic [DATAWIDTH-1:0] beat_data;
    logic [12:0]          stride;
    logic                 b_hs;
    logic                 r_hs;
    logic                 b_err;
    logic                 r_err;

    assign start_ok  = (state == S_IDLE) && start;
    assign last_beat = (beat_cnt == cfg_len);
    // Both the write pattern and the read-back expectation derive from the same
    // global beat index: first beat of this burst plus the position inside it.
    assign beat_pat  = cfg_seed + burst_k + {24'd0, beat_cnt};
    assign beat_data = {(DATAWIDTH/32){beat_pat}};
    assign stride    = ({5'd0, cfg_len} + 13'd1) << 4;

    assign b_hs  = (state == S_B) && m_axi_bvalid;
    assign r_hs  = (state == S_R) && m_axi_rvalid;
    assign b_err = (m_axi_bresp != 2'b00) || (m_axi_bid != ID);
    assign r_err = (m_axi_rdata != beat_data) || (m_axi_rresp != 2'b00) ||
                   (m_axi_rid != ID) || (m_axi_rlast != last_beat);

    assign busy = (state != S_IDLE) && (state != S_FIN);
    assign done = (state == S_FIN);
    // During the done cycle the final count is already settled, so report it directly.
    assign pass = done ? (err_cnt == 16'd0) : pass_q;

    assign m_axi_awid    = ID;
    assign m_axi_awaddr  = cur_addr;
    assign m_axi_awlen   = cfg_len;
    assign m_axi_awsize  = 3'b100;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = (state == S_AW);

    assign m_axi_wid     = ID;
    assign m_axi_wdata   = beat_data;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = last_beat;
    assign m_axi_wvalid  = (state == S_W);

    assign m_axi_bready  = (state == S_B);

    assign m_axi_arid    = ID;
    assign m_axi_araddr  = cur_addr;
    assign m_axi_arlen   = cfg_len;
    assign m_axi_arsize  = 3'b100;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = (state == S_AR);

    assign m_axi_rready  = (state == S_R);

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            state       <= S_IDLE;
            cfg_len     <= 8'd0;
            cfg_seed    <= 32'd0;
            cur_addr    <= '0;
            bursts_left <= 16'd0;
            beat_cnt    <= 8'd0;
            burst_k     <= 32'd0;
            pass_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cfg_len     <= burst_len;
                        cfg_seed    <= seed;
                        cur_addr    <= base_addr;
                        bursts_left <= num_bursts;
                        beat_cnt    <= 8'd0;
                        burst_k     <= 32'd0;
                        pass_q      <= 1'b0;
                        state       <= (num_bursts == 16'd0) ? S_FIN : S_AW;
                    end
                end
                S_AW: begin
                    if (m_axi_awready) begin
                        beat_cnt <= 8'd0;
                        state    <= S_W;
                    end
                end
                S_W: begin
                    if (m_axi_wready) begin
                        if (last_beat) begin
                            beat_cnt <= 8'd0;
                            state    <= S_B;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                S_B: begin
                    if (m_axi_bvalid) begin
                        state <= S_AR;
                    end
                end
                S_AR: begin
                    if (m_axi_arready) begin
                        state <= S_R;
                    end
                end
                S_R: begin
                    if (m_axi_rvalid) begin
                        if (last_beat) begin
                            beat_cnt    <= 8'd0;
                            burst_k     <= burst_k + {24'd0, cfg_len} + 32'd1;
                            cur_addr    <= cur_addr + ADDRWIDTH'(stride);
                            bursts_left <= bursts_left - 16'd1;
                            state       <= (bursts_left == 16'd1) ? S_FIN : S_AW;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
                end
                S_FIN: begin
                    pass_q <= (err_cnt == 16'd0);
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // One increment per bad B response or per bad R beat, however many fields disagree.
    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            err_cnt <= 16'd0;
        end else if (start_ok) begin
            err_cnt <= 16'd0;
        end else if (((b_hs && b_err) || (r_hs && r_err)) && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule
